// File: rtl/block_stream_pkg.sv
// Shared definitions for the packed block stream blocks: count width, block
// type and the count clamp used when a beat claims more blocks than it carries.
package block_stream_pkg;

  localparam int NUM_W          = 32;
  localparam int DEF_BLOCK_SIZE = 64;

  typedef logic [DEF_BLOCK_SIZE-1:0] block_t;

  function automatic logic [NUM_W-1:0] clamp_num(input logic [NUM_W-1:0] num,
                                                 input logic [NUM_W-1:0] cap);
    return (num > cap) ? cap : num;
  endfunction

endpackage

// File: rtl/block_splitter_if.sv
// Wide-in / narrow-out block stream bundle; slave is the splitter, master is
// the side that feeds input beats and accepts output beats.
interface block_splitter_if
  import block_stream_pkg::*;
#(
  parameter int BLOCK_SIZE     = 64,
  parameter int MAX_NUM_BLOCKS = 1,
  parameter int RATIO          = 2
);

  logic                                       in_valid;
  logic                                       in_ready;
  logic [RATIO*MAX_NUM_BLOCKS*BLOCK_SIZE-1:0] in_data;
  logic [NUM_W-1:0]                           in_num;
  logic                                       in_last;
  logic                                       ready_4_output;
  logic                                       out_valid;
  logic [MAX_NUM_BLOCKS*BLOCK_SIZE-1:0]       out_data;
  logic [NUM_W-1:0]                           out_num;
  logic                                       out_last;

  modport slave (
    input  in_valid, in_data, in_num, in_last, ready_4_output,
    output in_ready, out_valid, out_data, out_num, out_last
  );

  modport master (
    output in_valid, in_data, in_num, in_last, ready_4_output,
    input  in_ready, out_valid, out_data, out_num, out_last
  );

endinterface

// File: rtl/block_window_mux.sv
// Picks MAX_NUM_BLOCKS consecutive lanes starting at a run-time offset; lanes
// at or beyond the count come out as zero.
module block_window_mux #(
  parameter int BLOCK_SIZE     = 64,
  parameter int MAX_NUM_BLOCKS = 1,
  parameter int SRC_LANES      = 2,
  parameter int CW             = 2
) (
  input  logic [SRC_LANES*BLOCK_SIZE-1:0]      src,
  input  logic [CW-1:0]                        off,
  input  logic [CW-1:0]                        cnt,
  output logic [MAX_NUM_BLOCKS*BLOCK_SIZE-1:0] win
);

  always_comb begin
    win = '0;
    for (int i = 0; i < MAX_NUM_BLOCKS; i++) begin
      for (int j = 0; j < SRC_LANES; j++) begin
        if ((i < int'(cnt)) && (int'(off) + i == j)) begin
          win[i*BLOCK_SIZE +: BLOCK_SIZE] = src[j*BLOCK_SIZE +: BLOCK_SIZE];
        end
      end
    end
  end

endmodule

// File: rtl/block_splitter.sv
// Splits one wide packed beat into narrow beats of at most MAX_NUM_BLOCKS
// blocks. Output registers always hold the beat currently being offered.
//   state | meaning
//   EMPTY | no buffered beat, ready for input
//   EMIT  | out_* hold a beat; rem_q/off_q describe it and what follows
module block_splitter
  import block_stream_pkg::*;
#(
  parameter int BLOCK_SIZE     = 64,
  parameter int MAX_NUM_BLOCKS = 1,
  parameter int RATIO          = 2
) (
  input logic             clk,
  input logic             rst_n,
  block_splitter_if.slave bus
);

  localparam int TOT = RATIO * MAX_NUM_BLOCKS;
  localparam int CW  = $clog2(TOT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_NUM_BLOCKS);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] EMIT  = 1'b1;

  logic [0:0]                           state_q, state_d;
  logic [TOT*BLOCK_SIZE-1:0]            buf_q, buf_d;
  logic [CW-1:0]                        rem_q, rem_d;
  logic [CW-1:0]                        off_q, off_d;
  logic                                 last_q, last_d;
  logic                                 out_valid_q, out_valid_d;
  logic [MAX_NUM_BLOCKS*BLOCK_SIZE-1:0] out_data_q, out_data_d;
  logic [NUM_W-1:0]                     out_num_q, out_num_d;
  logic                                 out_last_q, out_last_d;

  logic                      hs, is_final, in_ready, accept;
  logic [CW-1:0]             n_cur, in_cnt, rem_step, off_step;
  logic [CW-1:0]             nxt_cnt, nxt_off, nxt_n;
  logic                      nxt_last;
  logic [TOT*BLOCK_SIZE-1:0] src_data;
  logic [MAX_NUM_BLOCKS*BLOCK_SIZE-1:0] win;

  block_window_mux #(
    .BLOCK_SIZE    (BLOCK_SIZE),
    .MAX_NUM_BLOCKS(MAX_NUM_BLOCKS),
    .SRC_LANES     (TOT),
    .CW            (CW)
  ) u_win (
    .src(src_data),
    .off(nxt_off),
    .cnt(nxt_cnt),
    .win(win)
  );

  always_comb begin
    n_cur    = (rem_q > MAX_C) ? MAX_C : rem_q;
    is_final = (rem_q <= MAX_C);
    hs       = out_valid_q & bus.ready_4_output;
    in_ready = rst_n & ((state_q == EMPTY) | (hs & is_final));
    accept   = bus.in_valid & in_ready;
    in_cnt   = CW'(clamp_num(bus.in_num, NUM_W'(TOT)));
    rem_step = rem_q - n_cur;
    off_step = off_q + n_cur;

    // A reload only happens when the buffer is spent, so one window mux
    // serves both the fresh input and the next slice of the buffer.
    src_data = accept ? bus.in_data : buf_q;
    nxt_off  = accept ? '0 : off_step;
    nxt_cnt  = accept ? in_cnt : rem_step;
    nxt_last = accept ? bus.in_last : last_q;
    nxt_n    = (nxt_cnt > MAX_C) ? MAX_C : nxt_cnt;

    state_d     = state_q;
    buf_d       = buf_q;
    rem_d       = rem_q;
    off_d       = off_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_num_d   = out_num_q;
    out_last_d  = out_last_q;

    if (accept) begin
      // Zero-count beats without last are swallowed without an output beat.
      state_d     = ((in_cnt != '0) || bus.in_last) ? EMIT : EMPTY;
      out_valid_d = (in_cnt != '0) || bus.in_last;
      buf_d       = bus.in_data;
      rem_d       = in_cnt;
      off_d       = '0;
      last_d      = bus.in_last;
      out_data_d  = win;
      out_num_d   = NUM_W'(nxt_n);
      out_last_d  = nxt_last & (nxt_cnt <= MAX_C);
    end else if (hs) begin
      if (rem_step != '0) begin
        rem_d      = rem_step;
        off_d      = off_step;
        out_data_d = win;
        out_num_d  = NUM_W'(nxt_n);
        out_last_d = nxt_last & (nxt_cnt <= MAX_C);
      end else begin
        state_d     = EMPTY;
        rem_d       = '0;
        off_d       = '0;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_num_d   = '0;
        out_last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      buf_q       <= '0;
      rem_q       <= '0;
      off_q       <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_num_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      rem_q       <= rem_d;
      off_q       <= off_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_num_q   <= out_num_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_num   = out_num_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_block_splitter.sv
// Directed bench for block_splitter with 2-block output beats and 4-block inputs.
module tb_block_splitter;
  import block_stream_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  block_splitter_if #(.BLOCK_SIZE(64), .MAX_NUM_BLOCKS(2), .RATIO(2)) bus ();

  block_splitter #(.BLOCK_SIZE(64), .MAX_NUM_BLOCKS(2), .RATIO(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  localparam block_t A = 64'hA000_0000_0000_000A;
  localparam block_t B = 64'hB000_0000_0000_000B;
  localparam block_t C = 64'hC000_0000_0000_000C;
  localparam block_t D = 64'hD000_0000_0000_000D;
  localparam block_t E = 64'hE000_0000_0000_000E;
  localparam block_t F = 64'hF000_0000_0000_000F;
  localparam block_t G = 64'h6000_0000_0000_0006;
  localparam block_t H = 64'h7000_0000_0000_0007;
  localparam block_t Z = 64'h0;

  // Observed beat packed as {valid, last, num, lane1, lane0}.
  function automatic logic [161:0] obs();
    return {bus.out_valid, bus.out_last, bus.out_num, bus.out_data};
  endfunction

  function automatic logic [161:0] beat(input logic v, input logic l,
                                        input logic [31:0] n,
                                        input block_t l1, input block_t l0);
    return {v, l, n, l1, l0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input block_t l3, input block_t l2, input block_t l1,
                       input block_t l0, input logic [31:0] num, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = {l3, l2, l1, l0};
    bus.in_num   = num;
    bus.in_last  = last;
  endtask

  // Present an input and return #1 after the edge where it was accepted.
  task automatic send(input block_t l3, input block_t l2, input block_t l1,
                      input block_t l0, input logic [31:0] num, input logic last);
    int k;
    drive(l3, l2, l1, l0, num, last);
    k = 0;
    while (!bus.in_ready && k < 20) begin
      step();
      k++;
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_ready_timeout got in_ready=%b want 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_num = '0; bus.in_last = 1'b0;
    bus.ready_4_output = 1'b1;
    rst_n = 1'b0;
    step(); step();
    n_cmp++;
    if (obs() !== '0) begin
      n_bad++; $display("FAIL reset_outputs got %h want 0", obs());
    end
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_partial();
    bus.ready_4_output = 1'b1;
    send(D, C, B, A, 3, 1'b1);
    n_cmp++;
    if (obs() !== beat(1, 0, 2, B, A)) begin
      n_bad++; $display("FAIL partial_beat1 got %h want %h", obs(), beat(1, 0, 2, B, A));
    end
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL partial_ready1 got %b want 0", bus.in_ready);
    end
    step();
    n_cmp++;
    if (obs() !== beat(1, 1, 1, Z, C)) begin
      n_bad++; $display("FAIL partial_beat2 got %h want %h", obs(), beat(1, 1, 1, Z, C));
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL partial_ready2 got %b want 1", bus.in_ready);
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL partial_idle got valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.ready_4_output = 1'b1;
    send(D, C, B, A, 3, 1'b1);
    bus.ready_4_output = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs() !== beat(1, 0, 2, B, A) || bus.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold cycle %0d got %h ready=%b want %h ready=0",
                 i, obs(), bus.in_ready, beat(1, 0, 2, B, A));
      end
      step();
    end
    bus.ready_4_output = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== beat(1, 0, 2, B, A)) begin
      n_bad++; $display("FAIL bp_release got %h want %h", obs(), beat(1, 0, 2, B, A));
    end
    step();
    n_cmp++;
    if (obs() !== beat(1, 1, 1, Z, C)) begin
      n_bad++; $display("FAIL bp_beat2 got %h want %h", obs(), beat(1, 1, 1, Z, C));
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_idle got valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_zero_count();
    bus.ready_4_output = 1'b1;
    send(D, C, B, A, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL zero_silent cycle %0d got valid=%b ready=%b want valid=0 ready=1",
                 i, bus.out_valid, bus.in_ready);
      end
      step();
    end
    send(D, C, B, A, 0, 1'b1);
    n_cmp++;
    if (obs() !== beat(1, 1, 0, Z, Z)) begin
      n_bad++; $display("FAIL zero_last_beat got %h want %h", obs(), beat(1, 1, 0, Z, Z));
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL zero_last_idle got valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_clamp();
    bus.ready_4_output = 1'b1;
    send(H, G, F, E, 7, 1'b1);
    n_cmp++;
    if (obs() !== beat(1, 0, 2, F, E)) begin
      n_bad++; $display("FAIL clamp_beat1 got %h want %h", obs(), beat(1, 0, 2, F, E));
    end
    step();
    n_cmp++;
    if (obs() !== beat(1, 1, 2, H, G)) begin
      n_bad++; $display("FAIL clamp_beat2 got %h want %h", obs(), beat(1, 1, 2, H, G));
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL clamp_idle got valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.ready_4_output = 1'b1;
    send(D, C, B, A, 4, 1'b0);
    drive(Z, Z, F, E, 2, 1'b1);
    n_cmp++;
    if (obs() !== beat(1, 0, 2, B, A) || bus.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_beat1 got %h ready=%b want %h ready=0",
               obs(), bus.in_ready, beat(1, 0, 2, B, A));
    end
    step();
    n_cmp++;
    if (obs() !== beat(1, 0, 2, D, C) || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_beat2 got %h ready=%b want %h ready=1",
               obs(), bus.in_ready, beat(1, 0, 2, D, C));
    end
    step();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (obs() !== beat(1, 1, 2, F, E)) begin
      n_bad++; $display("FAIL b2b_beat3 got %h want %h", obs(), beat(1, 1, 2, F, E));
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL b2b_idle got valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus.ready_4_output = 1'b1;
    send(D, C, B, A, 4, 1'b1);
    n_cmp++;
    if (obs() !== beat(1, 0, 2, B, A)) begin
      n_bad++; $display("FAIL rstmid_beat1 got %h want %h", obs(), beat(1, 0, 2, B, A));
    end
    rst_n = 1'b0;
    step();
    n_cmp++;
    if (obs() !== '0 || bus.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_cleared got %h ready=%b want 0 ready=0", obs(), bus.in_ready);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_release got valid=%b ready=%b want valid=0 ready=1",
               bus.out_valid, bus.in_ready);
    end
    send(Z, Z, Z, G, 1, 1'b1);
    n_cmp++;
    if (obs() !== beat(1, 1, 1, Z, G)) begin
      n_bad++; $display("FAIL rstmid_new_beat got %h want %h", obs(), beat(1, 1, 1, Z, G));
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_idle got valid=%b want 0", bus.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_partial();
    test_backpressure();
    test_zero_count();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/block_splitter.md
# block_splitter

Receive-side counterpart of the two-stream block packer. Accepts one wide beat of up to RATIO*MAX_NUM_BLOCKS packed BLOCK_SIZE-bit blocks with a valid count, and re-emits it as a sequence of narrow beats of at most MAX_NUM_BLOCKS blocks each. Sits between a packed stream source and a narrow block consumer. Uses valid/ready handshakes on both sides and registers the outputs.

## Interface
- BLOCK_SIZE, 64, bits per block
- MAX_NUM_BLOCKS, 1, blocks per output beat
- RATIO, 2, input width as a multiple of output width (>=1)
- clk  input  1  clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid & in_ready at clk edge
- in_data  input  RATIO*MAX_NUM_BLOCKS x BLOCK_SIZE  packed blocks, lane 0 first
- in_num  input  32  valid block count in in_data
- in_last  input  1  final beat of packet
- ready_4_output  input  1  downstream ready
- out_valid  output  1  output beat valid
- out_data  output  MAX_NUM_BLOCKS x BLOCK_SIZE  output blocks, lane 0 first
- out_num  output  32  valid blocks in out_data (0..MAX_NUM_BLOCKS)
- out_last  output  1  final output beat of a last-flagged input beat

## Operation
- Internal state: buffer (data, remaining count rem, lane offset off, last flag) and FSM {EMPTY, EMIT}.
- Accept: latch in_data and last. Set rem = min(in_num, RATIO*MAX_NUM_BLOCKS) and off = 0. Go to EMIT.
- In EMIT, the current beat has n = min(rem, MAX_NUM_BLOCKS):
  - out_data lanes 0..n-1 = buffer lanes off..off+n-1; lanes n and above = 0.
  - out_num = n.
  - out_last = last & (rem <= MAX_NUM_BLOCKS).
- On out_valid & ready_4_output: rem -= n and off += n. When rem reaches 0, go to EMPTY, or reload if a new input is accepted in the same cycle.
- rem = 0 at accept:
  - in_last = 1: one beat with out_num = 0, out_last = 1.
  - in_last = 0: beat consumed silently, no output, FSM stays EMPTY.
- in_num > RATIO*MAX_NUM_BLOCKS is clamped. Blocks beyond in_num are never emitted.
- in_ready = (state == EMPTY) | (out_valid & ready_4_output & final beat). This allows back-to-back input without bubbles.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_num = 0, out_last = 0, state = EMPTY, rem = 0, off = 0.
- in_ready is combinational from state, rem and ready_4_output. It is 0 during reset.
- No combinational path from in_* to out_*. All out_* come from registers.
- Latency: input accepted at edge k gives the first output beat valid in cycle k+1.
- Throughput: one output beat per cycle while ready_4_output = 1. An input of r blocks takes max(1, ceil(r/MAX_NUM_BLOCKS)) cycles.
- Backpressure: while out_valid & ~ready_4_output, out_* hold stable and in_ready = 0 unless state == EMPTY.
- Simultaneous final-beat handshake and input accept: the buffer reloads, and the next beat is valid in the following cycle with no gap.
- Reset mid-packet: the buffer is discarded, outputs return to reset values the next cycle, and no partial beat is emitted after reset.
- Width rules:
  - rem and off are clog2(RATIO*MAX_NUM_BLOCKS+1) bits.
  - in_num is compared at full 32 bits before clamping.
  - out_num is zero-extended to 32 bits.

## Structure
- Shared package block_stream_pkg:
  - NUM_W = 32
  - block_t typedef (logic [BLOCK_SIZE-1:0])
  - clamp_num function
- The FSM enum {EMPTY, EMIT} is local.
- One sub-module: block_window_mux. It selects MAX_NUM_BLOCKS lanes at a run-time offset and zeroes lanes at or beyond the count. It is combinational and instantiated once.

## Test plan
Bench parameters: BLOCK_SIZE=64, MAX_NUM_BLOCKS=2, RATIO=2.
- Partial beat: in_num=3, lanes {A,B,C,D}, in_last=1, ready=1 -> beat 1 {A,B} num 2 last 0; beat 2 {C,0} num 1 last 1; in_ready=0 for exactly one cycle.
- Backpressure: the same input with ready_4_output=0 for 4 cycles after the first beat -> {A,B} held stable for 4 cycles, then {C,0} follows; no duplication or loss.
- Zero count: in_num=0, last=0 -> no out_valid. in_num=0, last=1 -> one beat num 0, last 1, out_data=0.
- Clamp: in_num=7 -> exactly two beats, num 2 and 2; lanes from the input only.
- Back-to-back: inputs num 4 (last 0) then num 2 (last 1) with ready=1 -> three consecutive out_valid cycles with num 2, 2, 2; out_last only on the third.
- Reset mid-packet: assert rst_n=0 after the first beat of a 4-block input -> next cycle out_valid=0 and outputs zero; after release, a new num=1 input emits a single correct beat.
